// File: rtl/ysyx_25030085_pkg.sv
// Shared types and constants for the ysyx_25030085 fetch path.
package ysyx_25030085_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_HOLD = 2'b11
   } ifu_state_e;

   localparam logic [1:0]  FAULT_NONE     = 2'b00;
   localparam logic [1:0]  FAULT_BUS      = 2'b01;
   localparam logic [1:0]  FAULT_MISALIGN = 2'b10;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_25030085_ifu_slot.sv
// Single-entry registered output slot (pc, inst, fault) toward decode.
module ysyx_25030085_ifu_slot
   import ysyx_25030085_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] load_pc_i,
   input  logic [31:0] load_inst_i,
   input  logic [1:0]  load_fault_i,
   input  logic        flush_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic [1:0]  fault_o
);

   logic        valid_q;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [1:0]  fault_q;

   // A load in the same cycle as a consume or flush wins: the new entry replaces the old.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         fault_q <= FAULT_NONE;
      end else if (load_i) begin
         valid_q <= 1'b1;
         pc_q    <= load_pc_i;
         inst_q  <= load_inst_i;
         fault_q <= load_fault_i;
      end else if (flush_i || (valid_q && ready_i)) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign inst_o  = inst_q;
   assign fault_o = fault_q;

endmodule

// File: rtl/ysyx_25030085_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time and hands words to decode.
module ysyx_25030085_ifu
   import ysyx_25030085_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic [1:0]  out_fault
);

   ifu_state_e  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        kill_q, kill_d;
   logic        pend_q, pend_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] req_addr_q, req_addr_d;

   logic        launch;
   logic [31:0] launch_pc;
   logic        slot_load, slot_flush;
   logic [31:0] slot_pc, slot_inst;
   logic [1:0]  slot_fault;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_d      = kill_q;
      pend_d      = pend_q;
      pend_pc_d   = pend_pc_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      launch      = 1'b0;
      launch_pc   = pc_q;
      slot_load   = 1'b0;
      slot_flush  = 1'b0;
      slot_pc     = pc_q;
      slot_inst   = NOP_INST;
      slot_fault  = FAULT_NONE;

      case (state_q)
         ST_IDLE: begin
            launch    = 1'b1;
            launch_pc = redirect_valid ? redirect_pc : pc_q;
         end
         ST_REQ: begin
            if (imem_req_ready) begin
               state_d     = ST_WAIT;
               req_valid_d = 1'b0;
               // The accepted request is stale if any redirect arrived while it was posted.
               if (redirect_valid) begin
                  pc_d   = redirect_pc;
                  kill_d = 1'b1;
                  pend_d = 1'b0;
               end else if (pend_q) begin
                  pc_d   = pend_pc_q;
                  kill_d = 1'b1;
                  pend_d = 1'b0;
               end
            end else if (redirect_valid) begin
               pend_d    = 1'b1;
               pend_pc_d = redirect_pc;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               if (kill_q || redirect_valid) begin
                  kill_d    = 1'b0;
                  launch    = 1'b1;
                  launch_pc = redirect_valid ? redirect_pc : pc_q;
               end else begin
                  slot_load  = 1'b1;
                  slot_pc    = pc_q;
                  slot_inst  = imem_rsp_err ? NOP_INST : imem_rsp_data;
                  slot_fault = imem_rsp_err ? FAULT_BUS : FAULT_NONE;
                  state_d    = ST_HOLD;
               end
            end else if (redirect_valid) begin
               pc_d   = redirect_pc;
               kill_d = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               slot_flush = 1'b1;
               launch     = 1'b1;
               launch_pc  = redirect_pc;
            end else if (out_valid && out_ready) begin
               launch    = 1'b1;
               launch_pc = pc_q + 32'd4;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A misaligned target never reaches the bus; it becomes a fault slot instead.
      if (launch) begin
         pc_d = launch_pc;
         if (pc_misaligned(launch_pc)) begin
            state_d     = ST_HOLD;
            req_valid_d = 1'b0;
            slot_load   = 1'b1;
            slot_pc     = launch_pc;
            slot_inst   = NOP_INST;
            slot_fault  = FAULT_MISALIGN;
         end else begin
            state_d     = ST_REQ;
            req_valid_d = 1'b1;
            req_addr_d  = launch_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         kill_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_pc_q   <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_q      <= kill_d;
         pend_q      <= pend_d;
         pend_pc_q   <= pend_pc_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_req_addr  = req_addr_q;

   ysyx_25030085_ifu_slot u_slot (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (slot_load),
      .load_pc_i    (slot_pc),
      .load_inst_i  (slot_inst),
      .load_fault_i (slot_fault),
      .flush_i      (slot_flush),
      .ready_i      (out_ready),
      .valid_o      (out_valid),
      .pc_o         (out_pc),
      .inst_o       (out_inst),
      .fault_o      (out_fault)
   );

endmodule

// File: tb/tb_ysyx_25030085_ifu.sv
// Directed bench for the fetch unit with a small request/response memory model.
module tb_ysyx_25030085_ifu;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [1:0]  out_fault;

   int          n_checks = 0;
   int          n_errors = 0;

   logic        rsp_pend = 1'b0;
   int          rsp_cnt = 0;
   int          rsp_delay = 0;
   logic [31:0] rsp_addr = '0;
   logic        stale_next = 1'b0;
   logic [31:0] err_addr = '0;

   ysyx_25030085_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_fault      (out_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: note acceptance before the edge, then drive the memory response after it.
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      if (acc) begin
         rsp_pend = 1'b1;
         rsp_cnt  = rsp_delay;
         rsp_addr = a;
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      imem_rsp_data  = '0;
      if (rsp_pend) begin
         if (rsp_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_err   = (rsp_addr == err_addr);
            imem_rsp_data  = stale_next ? 32'hDEAD_BEEF : mem_word(rsp_addr);
            stale_next     = 1'b0;
            rsp_pend       = 1'b0;
         end else begin
            rsp_cnt--;
         end
      end
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;

      @(posedge clk); @(posedge clk); #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr",  imem_req_addr, 32'h8000_0000);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pc",    out_pc, 32'h8000_0000);
      check("rst_out_inst",  out_inst, 32'h0000_0013);
      check("rst_out_fault", 32'(out_fault), 32'd0);
      rst = 1'b0;

      // Sequential fetch, zero wait states, one slot per three cycles.
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("seq_req_valid", 32'(imem_req_valid), 32'd1);
         check("seq_req_addr",  imem_req_addr, 32'h8000_0000 + 32'(4 * i));
         tick();
         check("seq_wait_noout", 32'(out_valid), 32'd0);
         tick();
         check("seq_out_valid", 32'(out_valid), 32'd1);
         check("seq_out_pc",    out_pc, 32'h8000_0000 + 32'(4 * i));
         check("seq_out_inst",  out_inst, mem_word(32'h8000_0000 + 32'(4 * i)));
         tick();
      end

      // Backpressure on the slot at 0x8000_000C.
      out_ready = 1'b0;
      check("bp_req_addr", imem_req_addr, 32'h8000_000C);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_pc",    out_pc, 32'h8000_000C);
         check("bp_out_inst",  out_inst, mem_word(32'h8000_000C));
         check("bp_no_req",    32'(imem_req_valid), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_next_req", imem_req_addr, 32'h8000_0010);

      // Redirect while waiting: the stale 0xDEADBEEF response must be dropped.
      rsp_delay  = 1;
      stale_next = 1'b1;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0100;
      tick();
      redirect_valid = 1'b0;
      check("rw_stale_rsp_seen", 32'(imem_rsp_valid), 32'd1);
      check("rw_no_req_yet",     32'(imem_req_valid), 32'd0);
      tick();
      check("rw_no_stale_out", 32'(out_valid), 32'd0);
      check("rw_req_valid",    32'(imem_req_valid), 32'd1);
      check("rw_req_addr",     imem_req_addr, 32'h8000_0100);
      rsp_delay = 0;
      tick();
      check("rw_no_stale_out2", 32'(out_valid), 32'd0);
      tick();
      check("rw_out_pc",   out_pc, 32'h8000_0100);
      check("rw_out_inst", out_inst, mem_word(32'h8000_0100));

      // Redirect during a stalled request: address held, response dropped.
      imem_req_ready = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0200;
      check("rr_req_addr0", imem_req_addr, 32'h8000_0104);
      tick();
      redirect_valid = 1'b0;
      check("rr_req_addr1", imem_req_addr, 32'h8000_0104);
      tick();
      check("rr_req_addr2", imem_req_addr, 32'h8000_0104);
      tick();
      check("rr_req_addr3", imem_req_addr, 32'h8000_0104);
      check("rr_req_valid", 32'(imem_req_valid), 32'd1);
      imem_req_ready = 1'b1;
      tick();
      check("rr_no_out_wait", 32'(out_valid), 32'd0);
      tick();
      check("rr_no_out_drop", 32'(out_valid), 32'd0);
      check("rr_req_target",  imem_req_addr, 32'h8000_0200);
      tick();
      tick();
      check("rr_out_pc",   out_pc, 32'h8000_0200);
      check("rr_out_inst", out_inst, mem_word(32'h8000_0200));

      // Redirect on the same cycle as the handshake, then a bus error on 0x8000_0008.
      err_addr       = 32'h8000_0008;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0008;
      tick();
      redirect_valid = 1'b0;
      check("err_req_addr", imem_req_addr, 32'h8000_0008);
      check("err_dropped",  32'(out_valid), 32'd0);
      tick();
      tick();
      check("err_out_valid", 32'(out_valid), 32'd1);
      check("err_out_fault", 32'(out_fault), 32'd1);
      check("err_out_inst",  out_inst, 32'h0000_0013);
      check("err_out_pc",    out_pc, 32'h8000_0008);
      err_addr = '0;
      tick();
      check("err_next_req", imem_req_addr, 32'h8000_000C);

      // Misaligned redirect out of a held slot.
      out_ready = 1'b0;
      tick();
      tick();
      check("mis_pre_pc", out_pc, 32'h8000_000C);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      check("mis_out_valid", 32'(out_valid), 32'd1);
      check("mis_out_fault", 32'(out_fault), 32'd2);
      check("mis_out_pc",    out_pc, 32'h8000_0102);
      check("mis_out_inst",  out_inst, 32'h0000_0013);
      check("mis_no_req",    32'(imem_req_valid), 32'd0);
      tick();
      check("mis_no_req2",   32'(imem_req_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      check("mis_plus4_pc",    out_pc, 32'h8000_0106);
      check("mis_plus4_fault", 32'(out_fault), 32'd2);
      check("mis_plus4_valid", 32'(out_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h8000_0000;
      tick();
      redirect_valid = 1'b0;
      check("mis_recover_req",  32'(imem_req_valid), 32'd1);
      check("mis_recover_addr", imem_req_addr, 32'h8000_0000);

      // Asynchronous reset mid-operation.
      #2;
      rst = 1'b1;
      #1;
      check("arst_req_valid", 32'(imem_req_valid), 32'd0);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_pc",    out_pc, 32'h8000_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
